demux_registrado_n: RTL and testbench

//  1-to-CANALES registered demultiplexer, ANCHO bits per word, with valid/ready handshake.

---
 rtl/demux_registrado_n_if.sv | 28 ++
 rtl/demux_registrado_n.sv | 79 +++++++
 tb/tb_demux_registrado_n.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_registrado_n_if.sv
// Handshake bundle between one producer, the registered demultiplexer and its CANALES consumers.
interface demux_registrado_n_if #(
  parameter int ANCHO   = 8,
  parameter int CANALES = 4
);
  localparam int SEL_W = $clog2(CANALES);

  logic [ANCHO-1:0]         entrada;
  logic                     entrada_valida;
  logic                     entrada_lista;
  logic [SEL_W-1:0]         sel;
  logic                     modo_auto;
  logic [CANALES*ANCHO-1:0] salida;
  logic [CANALES-1:0]       salida_valida;
  logic [CANALES-1:0]       salida_lista;
  logic [SEL_W-1:0]         canal_actual;
  logic                     error_sel;

  modport master (
    output entrada, entrada_valida, sel, modo_auto, salida_lista,
    input  entrada_lista, salida, salida_valida, canal_actual, error_sel
  );

  modport slave (
    input  entrada, entrada_valida, sel, modo_auto, salida_lista,
    output entrada_lista, salida, salida_valida, canal_actual, error_sel
  );
endinterface

// File: rtl/demux_registrado_n.sv
// 1-to-CANALES registered demultiplexer with per-channel one-word holding registers,
// manual (sel) or round-robin target selection and valid/ready handshake on both sides.
module demux_registrado_n #(
  parameter int ANCHO   = 8,
  parameter int CANALES = 4
) (
  input logic                 clk,
  input logic                 rst,
  demux_registrado_n_if.slave bus
);
  localparam int SEL_W = $clog2(CANALES);
  localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(CANALES - 1);

  logic [SEL_W-1:0]         target;
  logic [CANALES-1:0]       selMask;
  logic [CANALES-1:0]       libre;
  logic                     listo;
  logic                     accept;
  logic [CANALES-1:0]       writeEn;

  logic [CANALES*ANCHO-1:0] datosReg;
  logic [CANALES-1:0]       validosReg;
  logic [SEL_W-1:0]         canalReg;
  logic                     errorReg;

  // Target decode: an out-of-range sel yields an empty mask, so nothing is ready or written
  always_comb begin
    if (bus.modo_auto) begin
      target = canalReg;
    end else begin
      target = bus.sel;
    end
    for (int k = 0; k < CANALES; k++) begin
      selMask[k] = (target == SEL_W'(k));
    end
    libre   = ~validosReg | bus.salida_lista;
    listo   = |(selMask & libre);
    accept  = listo & bus.entrada_valida;
    writeEn = selMask & {CANALES{accept}};
  end

  // Channel registers, round-robin counter and invalid-select pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      datosReg   <= '0;
      validosReg <= '0;
      canalReg   <= '0;
      errorReg   <= 1'b0;
    end else begin
      for (int k = 0; k < CANALES; k++) begin
        if (writeEn[k]) begin
          datosReg[k*ANCHO +: ANCHO] <= bus.entrada;
          validosReg[k]              <= 1'b1;
        end else if (validosReg[k] && bus.salida_lista[k]) begin
          validosReg[k] <= 1'b0;
        end else begin
          validosReg[k] <= validosReg[k];
        end
      end
      if (accept && bus.modo_auto) begin
        if (canalReg == ULTIMO) begin
          canalReg <= '0;
        end else begin
          canalReg <= canalReg + SEL_W'(1);
        end
      end else begin
        canalReg <= canalReg;
      end
      errorReg <= bus.entrada_valida && !bus.modo_auto &&
                  (32'(bus.sel) >= 32'(CANALES));
    end
  end

  assign bus.entrada_lista = listo;
  assign bus.salida        = datosReg;
  assign bus.salida_valida = validosReg;
  assign bus.canal_actual  = canalReg;
  assign bus.error_sel     = errorReg;
endmodule

// File: tb/tb_demux_registrado_n.sv
// Bench for demux_registrado_n: vector table on a 4-channel instance, hand sequences on a
// 3-channel instance, then randomized traffic on both against a queue-based reference model.
module tb_demux_registrado_n;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  demux_registrado_n_if #(.ANCHO(8), .CANALES(4)) b4 ();
  demux_registrado_n_if #(.ANCHO(8), .CANALES(3)) b3 ();

  demux_registrado_n #(.ANCHO(8), .CANALES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  demux_registrado_n #(.ANCHO(8), .CANALES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  typedef struct {
    logic       modo;
    logic [1:0] sel;
    logic       val;
    logic [7:0] din;
    logic [3:0] lista;
    logic       expReady;
    logic [3:0] expValid;
    logic [1:0] expCanal;
    int         chkCh;
    logic [7:0] expByte;
  } vec_t;

  vec_t tbl [17];

  // Reference model: per-instance queue of accepted, not yet consumed words per channel
  logic [7:0] q [2][4][$];
  int         mCanal [2];
  int         nCh [2] = '{4, 3};

  logic       rModo [2];
  logic [1:0] rSel [2];
  logic       rVal [2];
  logic [7:0] rDin [2];
  logic [3:0] rLista [2];
  logic       obsReady [2];
  logic [31:0] obsData [2];
  logic [3:0] obsValid [2];
  logic [1:0] obsCanal [2];
  logic       obsErr [2];
  logic       expErr [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic randomInputs();
    b4.modo_auto = 1'($urandom_range(0, 1)); b4.sel = 2'($urandom_range(0, 3));
    b4.entrada_valida = 1'($urandom_range(0, 1)); b4.entrada = 8'($urandom);
    b4.salida_lista = 4'($urandom);
    b3.modo_auto = 1'($urandom_range(0, 1)); b3.sel = 2'($urandom_range(0, 3));
    b3.entrada_valida = 1'($urandom_range(0, 1)); b3.entrada = 8'($urandom);
    b3.salida_lista = 3'($urandom);
  endtask

  task automatic doReset();
    randomInputs();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid4", 32'(b4.salida_valida), 32'd0);
    chk("rst_data4",  32'(b4.salida),        32'd0);
    chk("rst_canal4", 32'(b4.canal_actual),  32'd0);
    chk("rst_err4",   32'(b4.error_sel),     32'd0);
    chk("rst_valid3", 32'(b3.salida_valida), 32'd0);
    chk("rst_data3",  32'(b3.salida),        32'd0);
    chk("rst_canal3", 32'(b3.canal_actual),  32'd0);
    chk("rst_err3",   32'(b3.error_sel),     32'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mCanal[i] = 0;
      for (int k = 0; k < 4; k++) q[i][k].delete();
    end
  endtask

  task automatic idle3();
    b3.modo_auto = 1'b0; b3.sel = 2'd0; b3.entrada_valida = 1'b0;
    b3.entrada = 8'd0; b3.salida_lista = 3'd0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 1'b1, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2'd0, 2, 8'hA5};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 8'h00, 4'b0100, 1'b1, 4'b0000, 2'd0, 2, 8'hA5};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 8'h11, 4'b0000, 1'b1, 4'b0010, 2'd0, 1, 8'h11};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 8'h22, 4'b0000, 1'b0, 4'b0010, 2'd0, 1, 8'h11};
    tbl[4]  = '{1'b0, 2'd1, 1'b1, 8'h3C, 4'b0010, 1'b1, 4'b0010, 2'd0, 1, 8'h3C};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 8'h00, 4'b0010, 1'b1, 4'b0000, 2'd0, 1, 8'h3C};
    tbl[6]  = '{1'b1, 2'd0, 1'b1, 8'h01, 4'b1111, 1'b1, 4'b0001, 2'd1, 0, 8'h01};
    tbl[7]  = '{1'b1, 2'd0, 1'b1, 8'h02, 4'b1111, 1'b1, 4'b0010, 2'd2, 1, 8'h02};
    tbl[8]  = '{1'b1, 2'd0, 1'b1, 8'h03, 4'b1111, 1'b1, 4'b0100, 2'd3, 2, 8'h03};
    tbl[9]  = '{1'b1, 2'd0, 1'b1, 8'h04, 4'b1111, 1'b1, 4'b1000, 2'd0, 3, 8'h04};
    tbl[10] = '{1'b1, 2'd0, 1'b1, 8'h05, 4'b1111, 1'b1, 4'b0001, 2'd1, 0, 8'h05};
    tbl[11] = '{1'b1, 2'd0, 1'b1, 8'h06, 4'b1111, 1'b1, 4'b0010, 2'd2, 1, 8'h06};
    tbl[12] = '{1'b0, 2'd2, 1'b1, 8'h07, 4'b0000, 1'b1, 4'b0110, 2'd2, 2, 8'h07};
    tbl[13] = '{1'b1, 2'd0, 1'b1, 8'h08, 4'b0000, 1'b0, 4'b0110, 2'd2, 3, 8'h04};
    tbl[14] = '{1'b1, 2'd0, 1'b1, 8'h08, 4'b0100, 1'b1, 4'b0110, 2'd3, 2, 8'h08};
    tbl[15] = '{1'b0, 2'd1, 1'b1, 8'h99, 4'b0000, 1'b0, 4'b0110, 2'd3, 1, 8'h06};
    tbl[16] = '{1'b1, 2'd0, 1'b0, 8'h00, 4'b0110, 1'b1, 4'b0000, 2'd3, 2, 8'h08};

    doReset();

    // Table-driven sequence on the 4-channel instance
    idle3();
    for (int r = 0; r < 17; r++) begin
      b4.modo_auto = tbl[r].modo; b4.sel = tbl[r].sel; b4.entrada_valida = tbl[r].val;
      b4.entrada = tbl[r].din; b4.salida_lista = tbl[r].lista;
      #1;
      chk($sformatf("tbl%0d_ready", r), 32'(b4.entrada_lista), 32'(tbl[r].expReady));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", r), 32'(b4.salida_valida), 32'(tbl[r].expValid));
      chk($sformatf("tbl%0d_canal", r), 32'(b4.canal_actual), 32'(tbl[r].expCanal));
      chk($sformatf("tbl%0d_err", r), 32'(b4.error_sel), 32'd0);
      chk($sformatf("tbl%0d_data", r), 32'(b4.salida[tbl[r].chkCh*8 +: 8]), 32'(tbl[r].expByte));
    end
    b4.entrada_valida = 1'b0; b4.salida_lista = 4'b0000;

    // 3-channel: invalid select, error pulse, then a valid word and an auto wrap
    b3.modo_auto = 1'b0; b3.sel = 2'd3; b3.entrada_valida = 1'b1; b3.entrada = 8'hFF;
    b3.salida_lista = 3'b000;
    #1;
    chk("inv_ready", 32'(b3.entrada_lista), 32'd0);
    @(posedge clk); #1;
    chk("inv_err", 32'(b3.error_sel), 32'd1);
    chk("inv_valid", 32'(b3.salida_valida), 32'd0);
    chk("inv_data", 32'(b3.salida), 32'd0);
    chk("inv_canal", 32'(b3.canal_actual), 32'd0);
    b3.entrada_valida = 1'b0;
    @(posedge clk); #1;
    chk("inv_err_clear", 32'(b3.error_sel), 32'd0);
    b3.sel = 2'd2; b3.entrada_valida = 1'b1; b3.entrada = 8'h5A;
    #1;
    chk("ok3_ready", 32'(b3.entrada_lista), 32'd1);
    @(posedge clk); #1;
    chk("ok3_valid", 32'(b3.salida_valida), 32'b100);
    chk("ok3_data", 32'(b3.salida[23:16]), 32'h5A);
    chk("ok3_err", 32'(b3.error_sel), 32'd0);
    b3.modo_auto = 1'b1; b3.salida_lista = 3'b111;
    for (int w = 0; w < 3; w++) begin
      b3.entrada = 8'(8'h30 + w);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_canal", w), 32'(b3.canal_actual), 32'((w + 1) % 3));
      chk($sformatf("wrap%0d_data", w), 32'(b3.salida[w*8 +: 8]), 32'(8'h30 + w));
    end

    // Randomized traffic on both instances against the queue model, reset mid-stream
    doReset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) doReset();
      for (int i = 0; i < 2; i++) begin
        rModo[i]  = 1'($urandom_range(0, 1));
        rSel[i]   = 2'($urandom_range(0, 3));
        rVal[i]   = ($urandom_range(0, 3) != 0);
        rDin[i]   = 8'($urandom);
        rLista[i] = 4'($urandom);
      end
      b4.modo_auto = rModo[0]; b4.sel = rSel[0]; b4.entrada_valida = rVal[0];
      b4.entrada = rDin[0]; b4.salida_lista = rLista[0];
      b3.modo_auto = rModo[1]; b3.sel = rSel[1]; b3.entrada_valida = rVal[1];
      b3.entrada = rDin[1]; b3.salida_lista = rLista[1][2:0];
      #1;
      obsReady[0] = b4.entrada_lista; obsData[0] = 32'(b4.salida);
      obsReady[1] = b3.entrada_lista; obsData[1] = 32'(b3.salida);
      for (int i = 0; i < 2; i++) begin
        int  t;
        logic expReady;
        t = rModo[i] ? mCanal[i] : int'(rSel[i]);
        expReady = (t < nCh[i]) && ((q[i][t].size() == 0) || rLista[i][t]);
        chk($sformatf("rnd%0d_ready", i), 32'(obsReady[i]), 32'(expReady));
        for (int k = 0; k < nCh[i]; k++) begin
          if (q[i][k].size() != 0) begin
            chk($sformatf("rnd%0d_ch%0d_word", i, k), 32'(obsData[i][k*8 +: 8]), 32'(q[i][k][0]));
            if (rLista[i][k]) void'(q[i][k].pop_front());
          end
        end
        if (rVal[i] && expReady) begin
          q[i][t].push_back(rDin[i]);
          if (rModo[i]) mCanal[i] = (mCanal[i] + 1) % nCh[i];
        end
        expErr[i] = rVal[i] && !rModo[i] && (int'(rSel[i]) >= nCh[i]);
      end
      @(posedge clk); #1;
      obsValid[0] = b4.salida_valida; obsCanal[0] = b4.canal_actual; obsErr[0] = b4.error_sel;
      obsValid[1] = 4'(b3.salida_valida); obsCanal[1] = b3.canal_actual; obsErr[1] = b3.error_sel;
      for (int i = 0; i < 2; i++) begin
        logic [3:0] expValid;
        expValid = 4'd0;
        for (int k = 0; k < nCh[i]; k++) expValid[k] = (q[i][k].size() != 0);
        chk($sformatf("rnd%0d_valid", i), 32'(obsValid[i]), 32'(expValid));
        chk($sformatf("rnd%0d_canal", i), 32'(obsCanal[i]), 32'(mCanal[i]));
        chk($sformatf("rnd%0d_err", i), 32'(obsErr[i]), 32'(expErr[i]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
